// File: rtl/wb_vmon_write_arbiter_pkg.sv
// Shared types and helpers for the vmon Wishbone write arbiter.
// Optional timeout feature is enabled with `define WB_VMON_ARB_TIMEOUT_EN.
package wb_vmon_arb_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  // Only naturally aligned byte, half-word and word lanes are legal.
  function automatic bit sel_legal(logic [3:0] sel);
    return sel inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

endpackage

// File: rtl/wb_vmon_write_arbiter_if.sv
// Classic single-beat Wishbone write bus between the arbiter (master) and the vmon window.
interface wb_vmon_write_arbiter_if #(
  parameter int unsigned WB_ADDR_WIDTH = 32
);
  logic [WB_ADDR_WIDTH-1:0]          ADR;
  logic [wb_vmon_arb_pkg::DATA_W-1:0] DAT_W;
  logic [3:0]                        SEL;
  logic                              CYC;
  logic                              STB;
  logic                              WE;
  logic                              ACK;
  logic                              ERR;

  modport master (
    output ADR, DAT_W, SEL, CYC, STB, WE,
    input  ACK, ERR
  );

  modport slave (
    input  ADR, DAT_W, SEL, CYC, STB, WE,
    output ACK, ERR
  );
endinterface

// File: rtl/wb_vmon_rr_arb.sv
// Combinational round-robin grant: first valid requester after ptr, wrapping at N_REQ-1.
module wb_vmon_rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  int idx;

  // Walk from farthest to nearest so the nearest valid requester overwrites the rest.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int off = int'(N_REQ); off >= 1; off--) begin
      idx = (int'(ptr) + off) % int'(N_REQ);
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_vmon_write_arbiter.sv
// Round-robin arbiter sharing the vmon Wishbone write window among N_REQ requesters.
// Define WB_VMON_ARB_TIMEOUT_EN to abort bus cycles after TIMEOUT cycles without ACK/ERR.
module wb_vmon_write_arbiter
  import wb_vmon_arb_pkg::*;
#(
  parameter int unsigned              N_REQ         = 4,
  parameter int unsigned              WB_ADDR_WIDTH = 32,
  parameter int unsigned              WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS       = '0,
  parameter int unsigned              TIMEOUT       = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_dat,
  input  logic [N_REQ*4-1:0]      req_sel,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic                    rsp_err,
  wb_vmon_write_arbiter_if.master wb
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (WB_DATA_WIDTH != DATA_W || N_REQ < 1 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_err
    $error("wb_vmon_write_arbiter: unsupported parameter set");
  end

  state_e             state_q, state_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic [3:0]         sel_q, sel_d;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   grant;
  logic [PtrW-1:0]    grant_idx;
  logic [DATA_W-1:0]  grant_dat;
  logic [3:0]         grant_sel;
  logic               tmo_hit;

  wb_vmon_rr_arb #(
    .N_REQ (N_REQ),
    .PTR_W (PtrW)
  ) u_rr_arb (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    grant_dat = '0;
    grant_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PtrW'(i);
        grant_dat = req_dat[DATA_W*i +: DATA_W];
        grant_sel = req_sel[4*i +: 4];
      end
    end
  end

`ifdef WB_VMON_ARB_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  // Held at zero outside BUS, so it starts from zero on every bus entry.
  always_comb tmo_d = (state_q == BUS) ? tmo_q + 16'd1 : 16'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end

  assign tmo_hit = (tmo_q == 16'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Reset gates ready so nothing is offered while the block is held in reset.
  assign req_ready = (state_q == IDLE && !rst_i) ? grant : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|req_ready) begin
          ptr_d   = grant_idx;
          owner_d = grant;
          dat_d   = grant_dat;
          sel_d   = grant_sel;
          if (sel_legal(grant_sel)) begin
            state_d = BUS;
            err_d   = 1'b0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      BUS: begin
        if (wb.ERR) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (wb.ACK) begin
          state_d = RESP;
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= PtrW'(N_REQ - 1);
      owner_q <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign wb.ADR    = ADDRESS;
  assign wb.DAT_W  = dat_q;
  assign wb.SEL    = sel_q;
  assign wb.CYC    = (state_q == BUS);
  assign wb.STB    = (state_q == BUS);
  assign wb.WE     = (state_q == BUS);
  assign rsp_valid = (state_q == RESP) ? owner_q : '0;
  assign rsp_err   = (state_q == RESP) && err_q;

endmodule
